power_monitor: RTL and testbench

- Supervises rail power-good feedback after the power sequencer finishes its power-up.
- Per-rail debounce of power-good inputs.
- After a post-sequence blanking window, any deasserted unmasked rail latches a fault and raises a power-down request back to the sequencer.
- Sits beside the sequencer in the power manager: consumes its power_up and sequence_complete, and drives its power_down input.

---
 rtl/power_monitor_pkg.sv | 32 +++
 rtl/power_monitor_pg_debounce.sv | 59 +++++
 rtl/power_monitor.sv | 176 +++++++++++++++++
 tb/tb_power_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_monitor_pkg.sv
// Shared definitions for the power monitor.
//
// Contents:
//   - POWER_MON_* : 2-bit FSM state encodings
//   - BLANK_CYCLES_DEFAULT : post-sequence blanking time
//       (short under SIMULATION so benches reach MONITOR quickly)
//   - RETRY_CYCLES_DEFAULT : automatic retry wait
//       (only present when POWER_MONITOR_RETRY_EN is defined)
//
// Macros: SIMULATION, POWER_MONITOR_RETRY_EN
package power_monitor_pkg;

   localparam logic [1:0] POWER_MON_IDLE    = 2'd0;
   localparam logic [1:0] POWER_MON_ARM     = 2'd1;
   localparam logic [1:0] POWER_MON_MONITOR = 2'd2;
   localparam logic [1:0] POWER_MON_FAULT   = 2'd3;

`ifdef SIMULATION
   localparam int BLANK_CYCLES_DEFAULT = 1;
`else
   localparam int BLANK_CYCLES_DEFAULT = 1000;
`endif

`ifdef POWER_MONITOR_RETRY_EN
`ifdef SIMULATION
   localparam int RETRY_CYCLES_DEFAULT = 100;
`else
   localparam int RETRY_CYCLES_DEFAULT = 100000;
`endif
`endif

endpackage

// File: rtl/power_monitor_pg_debounce.sv
// pg_debounce: synchroniser plus debounce filter for one power-good rail.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   pg_raw     unsynchronised power-good input, 1 = good
//   pg_status  filtered power-good; changes only after the synchronised
//              input has disagreed with it for DEBOUNCE_CYCLES cycles
module pg_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic pg_raw,
   output logic pg_status
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             status_q, status_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts consecutive disagreeing samples; the flip happens on the
   // DEBOUNCE_CYCLES-th one, so the counter only needs to reach N-1.
   always_comb begin
      sync1_d  = pg_raw;
      sync2_d  = sync1_q;
      status_d = status_q;
      cnt_d    = cnt_q;
      if (sync2_q == status_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         status_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         status_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pg_status = status_q;

endmodule

// File: rtl/power_monitor.sv
// power_monitor: supervises rail power-good feedback once the power
// sequencer reports completion, and requests a power-down on a rail fault.
//
// Ports:
//   clk                system clock
//   reset              asynchronous active-low reset
//   power_up           power-up request (shared with the sequencer)
//   sequence_complete  sequencer done flag
//   pg_raw             unsynchronised power-good inputs, 1 = good
//   pg_mask            1 = rail monitored
//   fault_clear        single-cycle pulse, clears the latched fault
//   power_down_req     power-down request to the sequencer
//   fault              latched fault flag
//   fault_source       rails that were bad when the fault latched
//   pg_status          debounced power-good values
//   monitor_active     high in MONITOR
//   retry_count        automatic retries used (0 unless retry enabled)
//
// Macro: POWER_MONITOR_RETRY_EN enables timed automatic retries from FAULT
// (up to 3). Without it, FAULT exits only via fault_clear.
//
// state    | meaning
// IDLE     | waiting for power_up and sequence_complete
// ARM      | blanking window after sequence completion, faults ignored
// MONITOR  | faults armed; any bad unmasked rail latches a fault
// FAULT    | fault latched, power-down requested
module power_monitor
   import power_monitor_pkg::*;
#(
   parameter int NUM_RAILS       = 8,
   parameter int DEBOUNCE_CYCLES = 16,
`ifdef POWER_MONITOR_RETRY_EN
   parameter int RETRY_CYCLES    = RETRY_CYCLES_DEFAULT,
`endif
   parameter int BLANK_CYCLES    = BLANK_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 power_up,
   input  logic                 sequence_complete,
   input  logic [NUM_RAILS-1:0] pg_raw,
   input  logic [NUM_RAILS-1:0] pg_mask,
   input  logic                 fault_clear,
   output logic                 power_down_req,
   output logic                 fault,
   output logic [NUM_RAILS-1:0] fault_source,
   output logic [NUM_RAILS-1:0] pg_status,
   output logic                 monitor_active,
   output logic [1:0]           retry_count
);

   // Blank timer loads N-1 and leaves ARM on terminal count 0, so MONITOR
   // is reached exactly BLANK_CYCLES cycles after ARM entry.
   localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

`ifdef POWER_MONITOR_RETRY_EN
   localparam int RETRY_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LOAD = RETRY_W'(RETRY_CYCLES - 1);

   logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
   logic [1:0]         retry_count_q, retry_count_d;
`endif

   logic [1:0]           state_q, state_d;
   logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
   logic                 fault_q, fault_d;
   logic [NUM_RAILS-1:0] fault_source_q, fault_source_d;
   logic [NUM_RAILS-1:0] bad_rails;
   logic                 bad;

   for (genvar i = 0; i < NUM_RAILS; i++) begin : g_rail
      pg_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_pg_debounce (
         .clk       (clk),
         .reset     (reset),
         .pg_raw    (pg_raw[i]),
         .pg_status (pg_status[i])
      );
   end

   assign bad_rails = ~pg_status & pg_mask;
   assign bad       = |bad_rails;

   always_comb begin
      state_d        = state_q;
      blank_cnt_d    = blank_cnt_q;
      fault_d        = fault_q;
      fault_source_d = fault_source_q;
`ifdef POWER_MONITOR_RETRY_EN
      retry_cnt_d    = retry_cnt_q;
      retry_count_d  = retry_count_q;
`endif
      case (state_q)
         POWER_MON_IDLE: begin
            if (power_up && sequence_complete) begin
               state_d     = POWER_MON_ARM;
               blank_cnt_d = BLANK_LOAD;
            end
         end
         POWER_MON_ARM: begin
            if (!power_up || !sequence_complete) begin
               state_d = POWER_MON_IDLE;
            end else if (blank_cnt_q == '0) begin
               state_d = POWER_MON_MONITOR;
            end else begin
               blank_cnt_d = blank_cnt_q - 1'b1;
            end
         end
         POWER_MON_MONITOR: begin
            // Dropping power_up is an intentional shutdown and wins over bad.
            if (!power_up) begin
               state_d = POWER_MON_IDLE;
            end else if (bad) begin
               state_d        = POWER_MON_FAULT;
               fault_d        = 1'b1;
               fault_source_d = bad_rails;
`ifdef POWER_MONITOR_RETRY_EN
               retry_cnt_d    = RETRY_LOAD;
`endif
            end
         end
         POWER_MON_FAULT: begin
            if (fault_clear && !power_up) begin
               state_d        = POWER_MON_IDLE;
               fault_d        = 1'b0;
               fault_source_d = '0;
`ifdef POWER_MONITOR_RETRY_EN
               retry_count_d  = 2'd0;
            end else if (retry_cnt_q != '0) begin
               retry_cnt_d = retry_cnt_q - 1'b1;
            end else if (retry_count_q != 2'd3) begin
               // fault and fault_source stay latched across the retry
               retry_count_d = retry_count_q + 2'd1;
               state_d       = POWER_MON_IDLE;
`endif
            end
         end
         default: state_d = POWER_MON_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= POWER_MON_IDLE;
         blank_cnt_q    <= '0;
         fault_q        <= 1'b0;
         fault_source_q <= '0;
`ifdef POWER_MONITOR_RETRY_EN
         retry_cnt_q    <= '0;
         retry_count_q  <= 2'd0;
`endif
      end else begin
         state_q        <= state_d;
         blank_cnt_q    <= blank_cnt_d;
         fault_q        <= fault_d;
         fault_source_q <= fault_source_d;
`ifdef POWER_MONITOR_RETRY_EN
         retry_cnt_q    <= retry_cnt_d;
         retry_count_q  <= retry_count_d;
`endif
      end
   end

   assign power_down_req = (state_q == POWER_MON_FAULT);
   assign monitor_active = (state_q == POWER_MON_MONITOR);
   assign fault          = fault_q;
   assign fault_source   = fault_source_q;
`ifdef POWER_MONITOR_RETRY_EN
   assign retry_count    = retry_count_q;
`else
   assign retry_count    = 2'd0;
`endif

endmodule

// File: tb/tb_power_monitor.sv
// Directed bench for power_monitor with DEBOUNCE_CYCLES=4, BLANK_CYCLES=4
// (and RETRY_CYCLES=200 when POWER_MONITOR_RETRY_EN is defined).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_power_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       power_up;
   logic       sequence_complete;
   logic [7:0] pg_raw;
   logic [7:0] pg_mask;
   logic       fault_clear;
   logic       power_down_req;
   logic       fault;
   logic [7:0] fault_source;
   logic [7:0] pg_status;
   logic       monitor_active;
   logic [1:0] retry_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   power_monitor #(
      .NUM_RAILS       (8),
      .DEBOUNCE_CYCLES (4),
`ifdef POWER_MONITOR_RETRY_EN
      .RETRY_CYCLES    (200),
`endif
      .BLANK_CYCLES    (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .power_up          (power_up),
      .sequence_complete (sequence_complete),
      .pg_raw            (pg_raw),
      .pg_mask           (pg_mask),
      .fault_clear       (fault_clear),
      .power_down_req    (power_down_req),
      .fault             (fault),
      .fault_source      (fault_source),
      .pg_status         (pg_status),
      .monitor_active    (monitor_active),
      .retry_count       (retry_count)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0; power_up = 1'b0; sequence_complete = 1'b0;
      fault_clear = 1'b0; pg_raw = 8'hFF; pg_mask = 8'hFF;
      step(2);
      n_checks++;
      if ({power_down_req, fault, monitor_active, retry_count} !== 5'b0)
         $display("FAIL reset_flags: pdr/fault/mon/retry=%b expected 00000",
                  {power_down_req, fault, monitor_active, retry_count});
      else n_pass++;
      n_checks++;
      if ({fault_source, pg_status} !== 16'h0)
         $display("FAIL reset_vectors: src=%h status=%h expected 00/00", fault_source, pg_status);
      else n_pass++;
      reset = 1'b1;
      step(10);
      n_checks++;
      if (pg_status !== 8'hFF) $display("FAIL reset_debounce_up: status=%h expected ff", pg_status);
      else n_pass++;
   endtask

   task automatic test_power_up;
      power_up = 1'b1; sequence_complete = 1'b1;
      step(4);
      n_checks++;
      if (monitor_active !== 1'b0) $display("FAIL blank_early: mon=%b expected 0", monitor_active);
      else n_pass++;
      step(1);
      n_checks++;
      if ({monitor_active, fault, power_down_req} !== 3'b100)
         $display("FAIL blank_end: mon/fault/pdr=%b expected 100", {monitor_active, fault, power_down_req});
      else n_pass++;
   endtask

   task automatic test_glitch;
      pg_raw[3] = 1'b0;
      step(3);
      pg_raw[3] = 1'b1;
      step(10);
      n_checks++;
      if ({pg_status, fault, monitor_active} !== {8'hFF, 2'b01})
         $display("FAIL glitch: status=%h fault=%b mon=%b expected ff 0 1", pg_status, fault, monitor_active);
      else n_pass++;
   endtask

   task automatic test_fault_detect;
      pg_raw[5] = 1'b0;
      step(6);
      n_checks++;
      if ({pg_status, fault, monitor_active} !== {8'hDF, 2'b01})
         $display("FAIL fault_pre: status=%h fault=%b mon=%b expected df 0 1", pg_status, fault, monitor_active);
      else n_pass++;
      step(1);
      n_checks++;
      if ({fault, power_down_req, monitor_active} !== 3'b110)
         $display("FAIL fault_latch: fault/pdr/mon=%b expected 110", {fault, power_down_req, monitor_active});
      else n_pass++;
      n_checks++;
      if ({fault_source, retry_count} !== {8'h20, 2'd0})
         $display("FAIL fault_source: src=%h retry=%0d expected 20 0", fault_source, retry_count);
      else n_pass++;
   endtask

   task automatic test_fault_clear;
      fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++;
      if ({fault, power_down_req} !== 2'b11)
         $display("FAIL clear_while_up: fault/pdr=%b expected 11", {fault, power_down_req});
      else n_pass++;
      pg_raw = 8'hFF;
      step(10);
      n_checks++;
      if ({pg_status, fault_source, power_down_req} !== {8'hFF, 8'h20, 1'b1})
         $display("FAIL source_frozen: status=%h src=%h pdr=%b expected ff 20 1",
                  pg_status, fault_source, power_down_req);
      else n_pass++;
      power_up = 1'b0; fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++;
      if ({fault, fault_source, power_down_req} !== 10'b0)
         $display("FAIL clear_down: fault=%b src=%h pdr=%b expected 0 00 0", fault, fault_source, power_down_req);
      else n_pass++;
   endtask

   task automatic test_mask;
      pg_mask = 8'hDF; pg_raw[5] = 1'b0; power_up = 1'b1;
      step(5);
      n_checks++;
      if (monitor_active !== 1'b1) $display("FAIL mask_arm: mon=%b expected 1", monitor_active);
      else n_pass++;
      step(10);
      n_checks++;
      if ({pg_status, fault, monitor_active} !== {8'hDF, 2'b01})
         $display("FAIL mask_ignore: status=%h fault=%b mon=%b expected df 0 1", pg_status, fault, monitor_active);
      else n_pass++;
      pg_mask = 8'hFF;
      step(1);
      n_checks++;
      if ({fault, fault_source} !== {1'b1, 8'h20})
         $display("FAIL mask_unmask: fault=%b src=%h expected 1 20", fault, fault_source);
      else n_pass++;
      power_up = 1'b0; fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++;
      if (fault !== 1'b0) $display("FAIL mask_clear: fault=%b expected 0", fault);
      else n_pass++;
   endtask

   task automatic test_shutdown_priority;
      pg_mask = 8'hDF; power_up = 1'b1;
      step(5);
      n_checks++;
      if (monitor_active !== 1'b1) $display("FAIL prio_arm: mon=%b expected 1", monitor_active);
      else n_pass++;
      pg_mask = 8'hFF; power_up = 1'b0;
      step(1);
      n_checks++;
      if ({fault, monitor_active, power_down_req} !== 3'b000)
         $display("FAIL prio_shutdown: fault/mon/pdr=%b expected 000", {fault, monitor_active, power_down_req});
      else n_pass++;
      step(3);
      n_checks++;
      if ({fault, power_down_req} !== 2'b00)
         $display("FAIL prio_idle: fault/pdr=%b expected 00", {fault, power_down_req});
      else n_pass++;
      pg_raw = 8'hFF;
      step(8);
   endtask

   task automatic test_arm_abort;
      power_up = 1'b1; sequence_complete = 1'b1;
      step(2);
      sequence_complete = 1'b0;
      step(8);
      n_checks++;
      if ({monitor_active, fault} !== 2'b00)
         $display("FAIL arm_abort: mon/fault=%b expected 00", {monitor_active, fault});
      else n_pass++;
      power_up = 1'b0; sequence_complete = 1'b1;
      step(1);
   endtask

   task automatic test_async_reset;
      power_up = 1'b1;
      step(2);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({pg_status, monitor_active, fault, power_down_req, fault_source, retry_count} !== 21'b0)
         $display("FAIL reset_mid_arm: status=%h mon=%b fault=%b pdr=%b src=%h retry=%0d expected all 0",
                  pg_status, monitor_active, fault, power_down_req, fault_source, retry_count);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1; power_up = 1'b0; pg_raw = 8'hDF;
      step(10);
      power_up = 1'b1;
      step(6);
      n_checks++;
      if ({fault, power_down_req} !== 2'b11)
         $display("FAIL reset_pre_fault: fault/pdr=%b expected 11", {fault, power_down_req});
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({fault, power_down_req, fault_source} !== 10'b0)
         $display("FAIL reset_mid_fault: fault=%b pdr=%b src=%h expected 0 0 00", fault, power_down_req, fault_source);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1; power_up = 1'b0; pg_raw = 8'hFF;
      step(10);
   endtask

`ifdef POWER_MONITOR_RETRY_EN
   // One retry period = 1 (IDLE->ARM) + 4 (blank) + 1 (MONITOR->FAULT) + 200 (retry wait)
   task automatic test_retry;
      int cycles;
      pg_raw[5] = 1'b0;
      step(10);
      power_up = 1'b1; sequence_complete = 1'b1;
      for (int r = 1; r <= 3; r++) begin
         cycles = 0;
         while (retry_count !== 2'(r) && cycles < 400) begin
            step(1);
            cycles++;
         end
         n_checks++;
         if (cycles != 206) $display("FAIL retry_%0d_time: cycles=%0d expected 206", r, cycles);
         else n_pass++;
         n_checks++;
         if ({fault, power_down_req} !== 2'b10)
            $display("FAIL retry_%0d_state: fault/pdr=%b expected 10", r, {fault, power_down_req});
         else n_pass++;
      end
      step(500);
      n_checks++;
      if ({retry_count, power_down_req, fault, fault_source} !== {2'd3, 2'b11, 8'h20})
         $display("FAIL retry_exhausted: retry=%0d pdr=%b fault=%b src=%h expected 3 1 1 20",
                  retry_count, power_down_req, fault, fault_source);
      else n_pass++;
      power_up = 1'b0; fault_clear = 1'b1;
      step(1);
      fault_clear = 1'b0;
      n_checks++;
      if ({retry_count, fault, power_down_req} !== 4'b0)
         $display("FAIL retry_clear: retry=%0d fault=%b pdr=%b expected 0 0 0", retry_count, fault, power_down_req);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_power_up();
      test_glitch();
      test_fault_detect();
      test_fault_clear();
      test_mask();
      test_shutdown_priority();
      test_arm_abort();
      test_async_reset();
`ifdef POWER_MONITOR_RETRY_EN
      test_retry();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t expected completion before 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
